// File: rtl/neural_pkg.sv
// Shared constants, types and helpers for the neural processor front end.
// Q16.16 words, 11-bit word addressing, 5-word records (4 inputs + 1 target).
package neural_pkg;

    localparam int ADDR_W       = 11;
    localparam int WORD_W       = 32;
    localparam int RECORD_WORDS = 5;
    localparam int DEPTH        = 2 ** ADDR_W;
    localparam int EXP_W        = ADDR_W + 2;

    localparam logic [WORD_W-1:0] Q16_ONE = 32'h0001_0000;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W:0]   cnt_t;
    typedef logic [EXP_W-1:0]  exp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_TRN,
        ST_HDR_TST,
        ST_PAYLOAD,
        ST_DONE,
        ST_ERROR
    } loader_state_e;

    // Two header words plus one record per sample; EXP_W bits hold the worst case of 2552.
    function automatic exp_t calc_expected(input logic [7:0] n_trn, input logic [7:0] n_tst);
        return exp_t'(2) + exp_t'(RECORD_WORDS) * (exp_t'(n_trn) + exp_t'(n_tst));
    endfunction

endpackage

// File: rtl/dataset_ram.sv
// Simple dual-port dataset RAM: one write port, one read port with registered output.
// Read data appears one cycle after the address; same-address read/write returns old data.
module dataset_ram
    import neural_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  word_t             i_wr_dat,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output word_t             o_rd_dat
);

    word_t r_mem [DEPTH];
    word_t r_rd_dat;

    // Array stays reset-free so it maps onto block RAM; only the output register clears.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_rd_dat <= '0;
        end else begin
            r_rd_dat <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/dataset_loader.sv
// Packs a little-endian byte stream into dataset RAM and holds the processor in reset until
// a well-formed dataset is loaded; in_ready drops outside the header/payload phases.
module dataset_loader
    import neural_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_start,
    input  logic              i_in_valid,
    input  logic [7:0]        i_in_data,
    output logic              o_in_ready,
    input  logic [ADDR_W-1:0] i_address,
    output word_t             o_mem_data,
    output logic              o_proc_rst,
    output logic              o_load_done,
    output logic              o_load_err,
    output logic [ADDR_W:0]   o_word_count
);

    loader_state_e r_state;
    loader_state_e w_next_state;
    logic [1:0]    r_lane;
    logic [23:0]   r_part;
    cnt_t          r_word_count;
    logic [7:0]    r_num_trn;
    exp_t          r_expected;

    logic  w_accept;
    logic  w_word_done;
    cnt_t  w_count_next;
    exp_t  w_expected;
    word_t w_wr_dat;

    // A byte offered alongside load_start is dropped, not carried into the new load.
    assign w_accept     = i_in_valid & o_in_ready & ~i_load_start;
    assign w_word_done  = w_accept & (r_lane == 2'd3);
    assign w_count_next = r_word_count + cnt_t'(1);
    assign w_wr_dat     = {i_in_data, r_part};
    assign w_expected   = calc_expected(r_num_trn, r_part[7:0]);
    assign o_word_count = r_word_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= ST_IDLE;
            r_lane       <= '0;
            r_part       <= '0;
            r_word_count <= '0;
            r_num_trn    <= '0;
            r_expected   <= '0;
        end else begin
            r_state <= w_next_state;
            if (i_load_start) begin
                r_lane       <= '0;
                r_part       <= '0;
                r_word_count <= '0;
            end else if (w_accept) begin
                r_lane <= r_lane + 2'd1;
                case (r_lane)
                    2'd0:    r_part[7:0]   <= i_in_data;
                    2'd1:    r_part[15:8]  <= i_in_data;
                    2'd2:    r_part[23:16] <= i_in_data;
                    default: r_part        <= '0;
                endcase
                if (w_word_done) begin
                    r_word_count <= w_count_next;
                    if (r_state == ST_HDR_TRN) begin
                        r_num_trn <= r_part[7:0];
                    end
                    if (r_state == ST_HDR_TST) begin
                        r_expected <= w_expected;
                    end
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (i_load_start) begin
            w_next_state = ST_HDR_TRN;
        end else begin
            case (r_state)
                ST_HDR_TRN: begin
                    if (w_word_done) w_next_state = ST_HDR_TST;
                end
                ST_HDR_TST: begin
                    if (w_word_done) begin
                        if (w_expected > exp_t'(DEPTH))      w_next_state = ST_ERROR;
                        else if (w_expected == exp_t'(2))    w_next_state = ST_DONE;
                        else                                 w_next_state = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_word_done && (exp_t'(w_count_next) == r_expected)) w_next_state = ST_DONE;
                end
                default: w_next_state = r_state;
            endcase
        end
    end

    always_comb begin
        o_in_ready  = 1'b0;
        o_load_done = 1'b0;
        o_load_err  = 1'b0;
        o_proc_rst  = 1'b1;
        case (r_state)
            ST_HDR_TRN, ST_HDR_TST, ST_PAYLOAD: o_in_ready = 1'b1;
            ST_DONE: begin
                o_load_done = 1'b1;
                o_proc_rst  = 1'b0;
            end
            ST_ERROR: o_load_err = 1'b1;
            default: o_in_ready = 1'b0;
        endcase
    end

    // Payload writes stop at expected-1 <= DEPTH-1, so the count MSB never reaches the address.
    dataset_ram u_ram (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_word_done),
        .i_wr_addr (r_word_count[ADDR_W-1:0]),
        .i_wr_dat  (w_wr_dat),
        .i_rd_addr (i_address),
        .o_rd_dat  (o_mem_data)
    );

endmodule
